slab_interval_sequencer: RTL and testbench



---
 rtl/slab_interval_sequencer.sv | 175 +++++++++++++++++
 tb/tb_slab_interval_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/slab_interval_sequencer.sv
// slab_interval_sequencer: finishes the ray/AABB slab test by reducing
// tmin/tmax through one shared FP subtract-and-compare unit.
module slab_interval_sequencer #(
    parameter int W       = 29,
    parameter int CMP_LAT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [W:0] tmin_x,
    input  logic [W:0] tmin_y,
    input  logic [W:0] tmin_z,
    input  logic [W:0] tmax_x,
    input  logic [W:0] tmax_y,
    input  logic [W:0] tmax_z,
    output logic [W:0] cmp_a,
    output logic [W:0] cmp_b,
    input  logic       cmp_less,
    output logic       busy,
    output logic       done,
    output logic       hit,
    output logic [W:0] tnear,
    output logic [W:0] tfar
);
    typedef enum logic [1:0] {IDLE, STEP, DONE} state_t;

    localparam logic [3:0] LAT = 4'(CMP_LAT);

    state_t     state, state_d;
    logic [2:0] step, step_d;
    logic [3:0] wcnt, wcnt_d;
    logic       busy_d, done_d, hit_d;
    logic       lt, lt_d;
    logic [W:0] tnear_d, tfar_d;
    logic [W:0] a_d, b_d;
    logic [W:0] near, near_d;
    logic [W:0] far, far_d;
    logic [W:0] mn [3];
    logic [W:0] mn_d [3];
    logic [W:0] mx [3];
    logic [W:0] mx_d [3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            step  <= '0;
            wcnt  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            hit   <= 1'b0;
            lt    <= 1'b0;
            tnear <= '0;
            tfar  <= '0;
            cmp_a <= '0;
            cmp_b <= '0;
            near  <= '0;
            far   <= '0;
            mn    <= '{default: '0};
            mx    <= '{default: '0};
        end else begin
            state <= state_d;
            step  <= step_d;
            wcnt  <= wcnt_d;
            busy  <= busy_d;
            done  <= done_d;
            hit   <= hit_d;
            lt    <= lt_d;
            tnear <= tnear_d;
            tfar  <= tfar_d;
            cmp_a <= a_d;
            cmp_b <= b_d;
            near  <= near_d;
            far   <= far_d;
            mn    <= mn_d;
            mx    <= mx_d;
        end
    end

    // Working near/far are kept apart from tnear/tfar so an aborted
    // test leaves the last completed interval visible.
    always_comb begin
        state_d = state;
        step_d  = step;
        wcnt_d  = wcnt;
        busy_d  = busy;
        done_d  = 1'b0;
        hit_d   = hit;
        lt_d    = lt;
        tnear_d = tnear;
        tfar_d  = tfar;
        a_d     = cmp_a;
        b_d     = cmp_b;
        near_d  = near;
        far_d   = far;
        mn_d    = mn;
        mx_d    = mx;
        unique case (state)
            IDLE: begin
                if (start) begin
                    mn_d    = '{tmin_x, tmin_y, tmin_z};
                    mx_d    = '{tmax_x, tmax_y, tmax_z};
                    a_d     = tmin_x;
                    b_d     = tmin_y;
                    busy_d  = 1'b1;
                    step_d  = '0;
                    wcnt_d  = '0;
                    state_d = STEP;
                end
            end
            STEP: begin
                if (abort) begin
                    busy_d  = 1'b0;
                    step_d  = '0;
                    wcnt_d  = '0;
                    state_d = IDLE;
                end else if (wcnt != LAT) begin
                    wcnt_d = wcnt + 4'd1;
                end else begin
                    wcnt_d = '0;
                    step_d = step + 3'd1;
                    // Next operands use the value updated on this edge.
                    case (step)
                        3'd0: begin
                            near_d = cmp_less ? mn[1] : mn[0];
                            a_d    = near_d;
                            b_d    = mn[2];
                        end
                        3'd1: begin
                            near_d = cmp_less ? mn[2] : near;
                            a_d    = mx[0];
                            b_d    = mx[1];
                        end
                        3'd2: begin
                            far_d = cmp_less ? mx[0] : mx[1];
                            a_d   = far_d;
                            b_d   = mx[2];
                        end
                        3'd3: begin
                            far_d = cmp_less ? far : mx[2];
                            a_d   = near;
                            b_d   = far_d;
                        end
                        3'd4: begin
                            lt_d = cmp_less;
                            a_d  = far;
                            b_d  = '0;
                        end
                        3'd5: begin
                            hit_d   = lt & ~cmp_less;
                            tnear_d = near;
                            tfar_d  = far;
                            done_d  = 1'b1;
                            step_d  = '0;
                            state_d = DONE;
                        end
                        default: begin
                            step_d  = '0;
                            busy_d  = 1'b0;
                            state_d = IDLE;
                        end
                    endcase
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_slab_interval_sequencer.sv
// Bench for slab_interval_sequencer: two instances (CMP_LAT 4 and 1)
// against behavioural comparators and an interval reference model.
module tb_slab_interval_sequencer;
    localparam int W = 29;
    typedef logic [W:0] word_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    logic  start4 = 1'b0;
    logic  start1 = 1'b0;
    logic  abort = 1'b0;
    word_t tmin_x = '0, tmin_y = '0, tmin_z = '0;
    word_t tmax_x = '0, tmax_y = '0, tmax_z = '0;
    word_t a4, b4, tn4, tf4, a1, b1, tn1, tf1;
    logic  less4, less1, busy4, done4, hit4, busy1, done1, hit1;
    logic [3:0] p4;

    int n_cmp = 0;
    int n_err = 0;

    word_t vec [6];
    word_t opa [6];
    word_t opb [6];
    word_t exp_near, exp_far;
    logic  exp_hit;
    bit    l4, l1;
    int    dc4, de4, dc1, de1;

    always #5 clk = ~clk;

    slab_interval_sequencer #(.W(W), .CMP_LAT(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .abort(abort),
        .tmin_x(tmin_x), .tmin_y(tmin_y), .tmin_z(tmin_z),
        .tmax_x(tmax_x), .tmax_y(tmax_y), .tmax_z(tmax_z),
        .cmp_a(a4), .cmp_b(b4), .cmp_less(less4),
        .busy(busy4), .done(done4), .hit(hit4),
        .tnear(tn4), .tfar(tf4)
    );

    slab_interval_sequencer #(.W(W), .CMP_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort),
        .tmin_x(tmin_x), .tmin_y(tmin_y), .tmin_z(tmin_z),
        .tmax_x(tmax_x), .tmax_y(tmax_y), .tmax_z(tmax_z),
        .cmp_a(a1), .cmp_b(b1), .cmp_less(less1),
        .busy(busy1), .done(done1), .hit(hit1),
        .tnear(tn1), .tfar(tf1)
    );

    function automatic real fp_val(word_t a);
        real m;
        if (a[W:W-1] == 2'b00) return 0.0;
        m = (1.0 + real'(a[15:0]) / 65536.0)
            * (2.0 ** real'(int'(a[W-3:16]) - 1023));
        return a[W-2] ? -m : m;
    endfunction

    // Difference is normal and negative only for finite, unequal a < b.
    function automatic bit fp_lt(word_t a, word_t b);
        if (a[W:W-1] > 2'b01 || b[W:W-1] > 2'b01) return 1'b0;
        return fp_val(a) < fp_val(b);
    endfunction

    function automatic word_t enc(real r);
        real   m;
        int    e;
        word_t w;
        w = '0;
        if (r == 0.0) return w;
        m = (r < 0.0) ? -r : r;
        e = 1023;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0) begin m = m * 2.0; e--; end
        w[W:W-1]  = 2'b01;
        w[W-2]    = (r < 0.0);
        w[W-3:16] = 11'(e);
        w[15:0]   = 16'(int'((m - 1.0) * 65536.0));
        return w;
    endfunction

    function automatic word_t rnd();
        word_t w;
        int    sel;
        w   = word_t'($urandom);
        sel = int'($urandom_range(15));
        if (sel == 0) return '0;
        if (sel == 1) w[W:W-1] = 2'b10;
        else if (sel == 2) w[W:W-1] = 2'b11;
        else begin
            w[W:W-1]  = 2'b01;
            w[W-3:16] = 11'(1020 + $urandom_range(6));
        end
        return w;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            p4    <= '0;
            less1 <= 1'b0;
        end else begin
            p4    <= {p4[2:0], fp_lt(a4, b4)};
            less1 <= fp_lt(a1, b1);
        end
    end
    assign less4 = p4[3];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy4"}, {31'd0, busy4}, 0);
        chk({tag, "_done4"}, {31'd0, done4}, 0);
        chk({tag, "_hit4"}, {31'd0, hit4}, 0);
        chk({tag, "_tn4"}, {2'd0, tn4}, 0);
        chk({tag, "_tf4"}, {2'd0, tf4}, 0);
        chk({tag, "_a4"}, {2'd0, a4}, 0);
        chk({tag, "_b4"}, {2'd0, b4}, 0);
        chk({tag, "_busy1"}, {31'd0, busy1}, 0);
        chk({tag, "_tn1"}, {2'd0, tn1}, 0);
        chk({tag, "_hit1"}, {31'd0, hit1}, 0);
    endtask

    // Interval reduction: running max of entries, running min of exits,
    // ties resolved the way a strict less-than chooses.
    task automatic model();
        word_t n, f;
        n = vec[0];
        opa[0] = vec[0]; opb[0] = vec[1];
        if (fp_lt(vec[0], vec[1])) n = vec[1];
        opa[1] = n; opb[1] = vec[2];
        if (fp_lt(n, vec[2])) n = vec[2];
        opa[2] = vec[3]; opb[2] = vec[4];
        f = fp_lt(vec[3], vec[4]) ? vec[3] : vec[4];
        opa[3] = f; opb[3] = vec[5];
        if (!fp_lt(f, vec[5])) f = vec[5];
        opa[4] = n; opb[4] = f;
        opa[5] = f; opb[5] = '0;
        exp_near = n;
        exp_far  = f;
        exp_hit  = fp_lt(n, f) && !fp_lt(f, '0);
    endtask

    task automatic kick(input bit s4, input bit s1);
        @(negedge clk);
        {tmin_x, tmin_y, tmin_z} = {vec[0], vec[1], vec[2]};
        {tmax_x, tmax_y, tmax_z} = {vec[3], vec[4], vec[5]};
        start4 = s4;
        start1 = s1;
        l4 = s4;
        l1 = s1;
        @(negedge clk);
        start4 = 1'b0;
        start1 = 1'b0;
        {tmin_x, tmin_y, tmin_z} = {rnd(), rnd(), rnd()};
        {tmax_x, tmax_y, tmax_z} = {rnd(), rnd(), rnd()};
    endtask

    // r counts edges after the start edge; outputs read mid-cycle.
    task automatic watch(input int n, input int rep, input int abt);
        dc4 = 0; de4 = -1; dc1 = 0; de1 = -1;
        for (int r = 0; r <= n; r++) begin
            if (done4) begin dc4++; if (de4 < 0) de4 = r; end
            if (done1) begin dc1++; if (de1 < 0) de1 = r; end
            if (l4 && r < 30 && (abt < 0 || r <= abt)) begin
                chk("ops_a4", {2'd0, a4}, {2'd0, opa[r/5]});
                chk("ops_b4", {2'd0, b4}, {2'd0, opb[r/5]});
            end
            if (l1 && r < 12) begin
                chk("ops_a1", {2'd0, a1}, {2'd0, opa[r/2]});
                chk("ops_b1", {2'd0, b1}, {2'd0, opb[r/2]});
            end
            if (l4 && r == 0) chk("busy4_on", {31'd0, busy4}, 1);
            if (l4 && abt < 0 && r == 31) chk("busy4_off", {31'd0, busy4}, 0);
            if (l1 && r == 13) chk("busy1_off", {31'd0, busy1}, 0);
            if (r == abt) chk("abort_busy_pre", {31'd0, busy4}, 1);
            if (abt >= 0 && r == abt + 1) chk("abort_busy", {31'd0, busy4}, 0);
            start4 = (r + 1 == rep);
            abort  = (r == abt);
            @(negedge clk);
        end
        start4 = 1'b0;
        abort  = 1'b0;
    endtask

    task automatic verify();
        if (l4) begin
            chk("done4_cnt", dc4, 1);
            chk("done4_edge", de4, 30);
            chk("tnear4", {2'd0, tn4}, {2'd0, exp_near});
            chk("tfar4", {2'd0, tf4}, {2'd0, exp_far});
            chk("hit4", {31'd0, hit4}, {31'd0, exp_hit});
        end
        if (l1) begin
            chk("done1_cnt", dc1, 1);
            chk("done1_edge", de1, 12);
            chk("tnear1", {2'd0, tn1}, {2'd0, exp_near});
            chk("tfar1", {2'd0, tf1}, {2'd0, exp_far});
            chk("hit1", {31'd0, hit1}, {31'd0, exp_hit});
        end
    endtask

    real dirs [4][6] = '{
        '{1.0, 2.0, 0.5, 5.0, 3.0, 4.0},
        '{4.0, 1.0, 1.0, 3.0, 5.0, 5.0},
        '{-5.0, -6.0, -7.0, -1.0, -2.0, -3.0},
        '{2.0, 2.0, 1.0, 2.0, 9.0, 9.0}
    };

    initial begin
        word_t p_near, p_far;
        logic  p_hit;

        @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;

        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 6; i++) vec[i] = enc(dirs[t][i]);
            model();
            kick(1'b1, 1'b1);
            watch(34, -1, -1);
            verify();
            if (t == 0) begin
                chk("hit_tnear_abs", {2'd0, tn4}, {2'd0, enc(2.0)});
                chk("hit_tfar_abs", {2'd0, tf4}, {2'd0, enc(3.0)});
                chk("hit_abs", {31'd0, hit4}, 1);
            end
        end

        for (int i = 0; i < 6; i++) vec[i] = enc(dirs[0][i]);
        model();
        kick(1'b1, 1'b0);
        watch(34, 10, -1);
        verify();

        p_near = exp_near;
        p_far  = exp_far;
        p_hit  = exp_hit;
        for (int i = 0; i < 6; i++) vec[i] = enc(dirs[1][i]);
        model();
        kick(1'b1, 1'b0);
        watch(34, -1, 12);
        chk("abort_done", dc4, 0);
        chk("abort_tnear", {2'd0, tn4}, {2'd0, p_near});
        chk("abort_tfar", {2'd0, tf4}, {2'd0, p_far});
        chk("abort_hit", {31'd0, hit4}, {31'd0, p_hit});

        kick(1'b1, 1'b1);
        repeat (17) @(negedge clk);
        rst = 1'b1;
        #1;
        chk_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) vec[i] = enc(dirs[0][i]);
        model();
        kick(1'b1, 1'b1);
        watch(34, -1, -1);
        verify();

        for (int it = 0; it < 30; it++) begin
            for (int i = 0; i < 6; i++) vec[i] = rnd();
            if ($urandom_range(3) == 0) vec[1] = vec[0];
            if ($urandom_range(3) == 0) vec[5] = vec[3 + $urandom_range(1)];
            model();
            kick(1'b1, 1'b1);
            watch(34, -1, -1);
            verify();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
